// File: rtl/bouncing_sprite_engine.sv
// Motion and pixel engine for the bouncing-squares demo: per-square position/direction/speed
// state, a one-square-per-cycle frame update sequencer, and a registered 2-2-2 RGB pixel.
module bouncing_sprite_engine #(
  parameter int N_SQUARES = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SIZE      = 32,
  parameter int COORD_W   = 10,
  parameter int SPEED_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic               wrap_mode,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               display_on,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_idx,
  input  logic [1:0]         cfg_sel,
  input  logic [COORD_W-1:0] cfg_data,
  output logic [5:0]         rgb,
  output logic               hit,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic [7:0]         bounce_count
);

  localparam int AW      = COORD_W + 1;
  localparam int IDX_W   = (N_SQUARES > 1) ? $clog2(N_SQUARES) : 1;
  localparam int SPD_MAX = (1 << SPEED_W) - 1;

  localparam logic [AW-1:0] MAX_X  = AW'(H_ACTIVE - SIZE);
  localparam logic [AW-1:0] MAX_Y  = AW'(V_ACTIVE - SIZE);
  localparam logic [AW-1:0] LIM_X  = AW'(H_ACTIVE);
  localparam logic [AW-1:0] LIM_Y  = AW'(V_ACTIVE);
  localparam logic [AW-1:0] SIZE_A = AW'(SIZE);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               neg;
    logic               flip;
  } step_t;

  // Direction is stored as "moving negative"; one extra bit of headroom keeps sums exact.
  function automatic step_t axis_step(input logic [COORD_W-1:0] pos, input logic neg,
                                      input logic [SPEED_W-1:0] spd, input logic wrap,
                                      input logic [AW-1:0] max_pos, input logic [AW-1:0] lim);
    logic [AW-1:0] p, s, sum, diff;
    step_t r;
    p      = AW'(pos);
    s      = AW'(spd);
    sum    = p + s;
    diff   = p - s;
    r.flip = 1'b0;
    if (wrap) begin
      if (!neg) r.pos = COORD_W'((sum >= lim) ? sum - lim : sum);
      else      r.pos = COORD_W'((p < s) ? diff + lim : diff);
    end else if (!neg) begin
      if (sum > max_pos) begin
        r.pos  = COORD_W'(max_pos);
        r.flip = 1'b1;
      end else begin
        r.pos = COORD_W'(sum);
      end
    end else if (p < s) begin
      r.pos  = '0;
      r.flip = 1'b1;
    end else begin
      r.pos = COORD_W'(diff);
    end
    r.neg = neg ^ r.flip;
    return r;
  endfunction

  function automatic logic [5:0] colour_of(input int i);
    case (i % 4)
      0:       return 6'b110000;
      1:       return 6'b001100;
      2:       return 6'b000011;
      default: return 6'b111100;
    endcase
  endfunction

  logic [COORD_W-1:0] x_q   [N_SQUARES];
  logic [COORD_W-1:0] y_q   [N_SQUARES];
  logic               dx_q  [N_SQUARES];
  logic               dy_q  [N_SQUARES];
  logic [SPEED_W-1:0] spd_q [N_SQUARES];

  logic [0:0]       state;
  logic [IDX_W-1:0] k;
  step_t            step_x, step_y;
  logic             last_k;

  assign step_x     = axis_step(x_q[k], dx_q[k], spd_q[k], wrap_mode, MAX_X, LIM_X);
  assign step_y     = axis_step(y_q[k], dy_q[k], spd_q[k], wrap_mode, MAX_Y, LIM_Y);
  assign busy       = (state == UPDATE);
  assign last_k     = (k == IDX_W'(N_SQUARES - 1));
  assign frame_done = busy & last_k;

  // NOTE: the square state is a handful of flops rather than a RAM, so every entry takes
  // its reset value; a block RAM here would have no reset and need an init sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        x_q[i]   <= COORD_W'(i * (H_ACTIVE / N_SQUARES));
        y_q[i]   <= COORD_W'(i * (V_ACTIVE / N_SQUARES));
        dx_q[i]  <= (i % 2 == 1);
        dy_q[i]  <= 1'b0;
        spd_q[i] <= SPEED_W'((i + 1 < SPD_MAX) ? i + 1 : SPD_MAX);
      end
    end else begin
      for (int i = 0; i < N_SQUARES; i++) begin
        if (busy && k == IDX_W'(i)) begin
          x_q[i]  <= step_x.pos;
          y_q[i]  <= step_y.pos;
          dx_q[i] <= step_x.neg;
          dy_q[i] <= step_y.neg;
        end
        // NOTE: non-blocking assignments let the later config write override only the
        // field it selects, while the update result still lands in the other fields.
        if (cfg_we && cfg_idx == 4'(i)) begin
          case (cfg_sel)
            2'd0: spd_q[i] <= cfg_data[SPEED_W-1:0];
            2'd1: x_q[i]   <= cfg_data;
            2'd2: y_q[i]   <= cfg_data;
            default: begin
              if (cfg_data[0]) dx_q[i] <= ~dx_q[i];
              if (cfg_data[1]) dy_q[i] <= ~dy_q[i];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      overrun      <= 1'b0;
      bounce_count <= '0;
    end else begin
      if (frame_tick && !pause && busy) overrun <= 1'b1;
      if (!busy) begin
        if (frame_tick && !pause) begin
          state <= UPDATE;
          k     <= '0;
        end
      end else begin
        bounce_count <= bounce_count + {7'd0, step_x.flip} + {7'd0, step_y.flip};
        if (last_k) state <= IDLE;
        else        k     <= k + 1'b1;
      end
    end
  end

  logic [5:0] pix_rgb;
  logic       pix_hit;

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    pix_rgb = '0;
    pix_hit = 1'b0;
    // Walk downwards so the lowest covering index is the last (winning) assignment.
    for (int i = N_SQUARES - 1; i >= 0; i--) begin
      if (AW'(hpos) >= AW'(x_q[i]) && AW'(hpos) < AW'(x_q[i]) + SIZE_A &&
          AW'(vpos) >= AW'(y_q[i]) && AW'(vpos) < AW'(y_q[i]) + SIZE_A) begin
        pix_rgb = colour_of(i);
        pix_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb <= '0;
      hit <= 1'b0;
    end else begin
      rgb <= display_on ? pix_rgb : 6'b000000;
      hit <= display_on & pix_hit;
    end
  end

endmodule

// File: tb/tb_bouncing_sprite_engine.sv
// Self-checking bench for bouncing_sprite_engine: directed scenarios plus randomized
// configuration/frame traffic, compared against an integer-arithmetic model of the squares.
module tb_bouncing_sprite_engine;

  localparam int N  = 4;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int S  = 32;
  localparam int CW = 10;
  localparam int SW = 3;

  logic          clk, rst, frame_tick, pause, wrap_mode, display_on, cfg_we;
  logic [CW-1:0] hpos, vpos, cfg_data;
  logic [3:0]    cfg_idx;
  logic [1:0]    cfg_sel;
  logic [5:0]    rgb;
  logic          hit, busy, frame_done, overrun;
  logic [7:0]    bounce_count;

  int tests = 0;
  int fails = 0;

  bouncing_sprite_engine #(
    .N_SQUARES(N), .H_ACTIVE(H), .V_ACTIVE(V), .SIZE(S), .COORD_W(CW), .SPEED_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause), .wrap_mode(wrap_mode),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .rgb(rgb), .hit(hit), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .bounce_count(bounce_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed directions (+1/-1), plain integer positions.
  int mx[N], my[N], mdx[N], mdy[N], msp[N];
  int mbounce;

  function automatic logic [5:0] colour(input int i);
    case (i % 4)
      0:       return 6'b110000;
      1:       return 6'b001100;
      2:       return 6'b000011;
      default: return 6'b111100;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = i * (H / N);
      my[i]  = i * (V / N);
      mdx[i] = (i % 2 == 0) ? 1 : -1;
      mdy[i] = 1;
      msp[i] = (i + 1 < 7) ? i + 1 : 7;
    end
    mbounce = 0;
  endfunction

  function automatic void move(input int p, input int d, input int sp, input int lim,
                               input bit wrap, output int np, output int nd, output int fl);
    int max_p;
    max_p = lim - S;
    nd = d;
    fl = 0;
    if (wrap) begin
      np = p + d * sp;
      if (np >= lim) np -= lim;
      if (np < 0)    np += lim;
    end else if (d > 0) begin
      if (p + sp > max_p) begin np = max_p; nd = -1; fl = 1; end
      else np = p + sp;
    end else begin
      if (p < sp) begin np = 0; nd = 1; fl = 1; end
      else np = p - sp;
    end
  endfunction

  function automatic void model_frame(input bit wrap);
    int np, nd, fl;
    for (int i = 0; i < N; i++) begin
      move(mx[i], mdx[i], msp[i], H, wrap, np, nd, fl);
      mx[i] = np; mdx[i] = nd; mbounce += fl;
      move(my[i], mdy[i], msp[i], V, wrap, np, nd, fl);
      my[i] = np; mdy[i] = nd; mbounce += fl;
    end
  endfunction

  function automatic void model_pixel(input int hp, input int vp, input bit don,
                                      output logic [5:0] c, output logic h);
    c = 6'b0;
    h = 1'b0;
    if (!don) return;
    for (int i = 0; i < N; i++) begin
      if (hp >= mx[i] && hp < mx[i] + S && vp >= my[i] && vp < my[i] + S) begin
        c = colour(i);
        h = 1'b1;
        return;
      end
    end
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic probe(input int hp, input int vp, input bit don);
    logic [5:0] e_rgb;
    logic       e_hit;
    if (hp < 0 || hp > 1023 || vp < 0 || vp > 1023) return;
    hpos = CW'(hp); vpos = CW'(vp); display_on = don;
    model_pixel(hp, vp, don, e_rgb, e_hit);
    @(negedge clk);
    tests++;
    if (rgb !== e_rgb) begin
      fails++;
      $display("FAIL pixel_rgb (%0d,%0d,on=%0d) got %b expected %b", hp, vp, don, rgb, e_rgb);
    end
    tests++;
    if (hit !== e_hit) begin
      fails++;
      $display("FAIL pixel_hit (%0d,%0d,on=%0d) got %b expected %b", hp, vp, don, hit, e_hit);
    end
  endtask

  task automatic check_pixels(input int n_rand);
    int xs[4], ys[4];
    for (int i = 0; i < N; i++) begin
      xs = '{mx[i] - 1, mx[i], mx[i] + S - 1, mx[i] + S};
      ys = '{my[i] - 1, my[i], my[i] + S - 1, my[i] + S};
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) probe(xs[a], ys[b], 1'b1);
    end
    for (int r = 0; r < n_rand; r++)
      probe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), ($urandom_range(0, 3) != 0));
  endtask

  task automatic check_bounce(input string tag);
    tests++;
    if (bounce_count !== 8'(mbounce)) begin
      fails++;
      $display("FAIL bounce_count_%s got %0d expected %0d", tag, bounce_count, 8'(mbounce));
    end
  endtask

  task automatic run_frame(input bit chk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int c = 1; c <= N; c++) begin
      if (chk) begin
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_cycle%0d got %b expected 1", c, busy); end
        if (frame_done !== (c == N)) begin
          fails++; $display("FAIL frame_done_cycle%0d got %b expected %b", c, frame_done, (c == N));
        end
      end
      @(negedge clk);
    end
    if (chk) begin
      tests += 2;
      if (busy !== 1'b0) begin fails++; $display("FAIL busy_after got %b expected 0", busy); end
      if (frame_done !== 1'b0) begin fails++; $display("FAIL frame_done_after got %b expected 0", frame_done); end
    end
    model_frame(wrap_mode);
  endtask

  task automatic cfg_write(input int idx, input int sel, input int data);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_sel = 2'(sel); cfg_data = CW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    if (idx < N) begin
      case (sel)
        0: msp[idx] = data % 8;
        1: mx[idx]  = data;
        2: my[idx]  = data;
        default: begin
          if (data % 2 == 1)       mdx[idx] = -mdx[idx];
          if ((data / 2) % 2 == 1) mdy[idx] = -mdy[idx];
        end
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wrap_mode = 1'b0; pause = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [5:0] want;
    repeat (2) @(negedge clk);
    tests++;
    if ({rgb, hit, busy, frame_done, overrun, bounce_count} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs got %b expected 0", {rgb, hit, busy, frame_done, overrun, bounce_count});
    end
    rst = 1'b0;
    model_reset();
    hpos = 0; vpos = 0; display_on = 1'b1;
    @(negedge clk);
    tests++;
    if (rgb !== 6'b110000) begin fails++; $display("FAIL reset_pixel00 got %b expected 110000", rgb); end
    hpos = 160; vpos = 120;
    want = 6'b001100;
    @(negedge clk);
    tests++;
    if (rgb !== want) begin fails++; $display("FAIL reset_square1 got %b expected %b", rgb, want); end
    check_pixels(10);
  endtask

  task automatic test_frame_timing();
    run_frame(1'b1);
    check_pixels(6);
    check_bounce("frame");
  endtask

  task automatic test_overrun();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_early got %b expected 0", overrun); end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    tests += 2;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b expected 1", overrun); end
    if (busy !== 1'b1) begin fails++; $display("FAIL overrun_busy got %b expected 1", busy); end
    repeat (2) @(negedge clk);
    tests += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL overrun_no_retrigger got %b expected 0", busy); end
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b expected 1", overrun); end
    model_frame(wrap_mode);
    check_pixels(4);
  endtask

  task automatic test_bounce_right();
    do_reset();
    repeat (608) run_frame(1'b0);
    probe(608, my[0], 1'b1);
    check_pixels(4);
    run_frame(1'b1);
    check_bounce("right_hit");
    check_pixels(4);
    run_frame(1'b0);
    check_pixels(4);
    check_bounce("right_after");
  endtask

  task automatic test_bounce_left();
    do_reset();
    repeat (80) run_frame(1'b0);
    check_pixels(2);
    run_frame(1'b0);
    check_pixels(2);
    check_bounce("left_hit");
    run_frame(1'b0);
    check_pixels(2);
  endtask

  task automatic test_wrap();
    do_reset();
    wrap_mode = 1'b1;
    cfg_write(0, 1, 639);
    run_frame(1'b1);
    check_bounce("wrap");
    check_pixels(4);
    run_frame(1'b0);
    check_pixels(2);
    wrap_mode = 1'b0;
  endtask

  task automatic test_overlap_pause();
    do_reset();
    cfg_write(0, 1, 100); cfg_write(0, 2, 100);
    cfg_write(2, 1, 100); cfg_write(2, 2, 100);
    hpos = 110; vpos = 110; display_on = 1'b1;
    @(negedge clk);
    tests++;
    if (rgb !== 6'b110000) begin fails++; $display("FAIL overlap_priority got %b expected 110000", rgb); end
    pause = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests += 2;
      if (busy !== 1'b0) begin fails++; $display("FAIL pause_busy got %b expected 0", busy); end
      if (overrun !== 1'b0) begin fails++; $display("FAIL pause_overrun got %b expected 0", overrun); end
      @(negedge clk);
    end
    pause = 1'b0;
    check_pixels(4);
  endtask

  task automatic test_cfg_collision();
    do_reset();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_sel = 2'd1; cfg_data = 10'd300;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (N - 1) @(negedge clk);
    model_frame(1'b0);
    mx[0] = 300;
    check_pixels(4);
    cfg_write(9, 1, 5);
    check_pixels(0);
  endtask

  task automatic test_async_reset();
    run_frame(1'b0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy got %b expected 0", busy); end
    if (bounce_count !== 8'd0) begin fails++; $display("FAIL async_reset_count got %0d expected 0", bounce_count); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_pixels(4);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3))
        cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
      wrap_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        pause = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; pause = 1'b0;
      end
      repeat ($urandom_range(1, 6)) run_frame(1'b0);
      check_pixels(8);
      check_bounce("random");
    end
    wrap_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; pause = 1'b0; wrap_mode = 1'b0;
    hpos = '0; vpos = '0; display_on = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    test_reset();
    test_frame_timing();
    test_overrun();
    test_bounce_right();
    test_bounce_left();
    test_wrap();
    test_overlap_pause();
    test_cfg_collision();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bouncing_sprite_engine.md
# bouncing_sprite_engine

Parametrised N-square motion and pixel engine for the bouncing-squares VGA demo. Holds position, direction and speed for `N_SQUARES` squares, advances them once per frame through a time-shared update sequencer, and produces a registered 2-2-2 RGB pixel for the current beam position. It sits between the VGA timing generator and the output pin mux. It adds a bounce/wrap mode, runtime per-square configuration and overrun detection.

## Interface
- `N_SQUARES`, 4, number of squares (1..16)
- `H_ACTIVE`, 640, visible width in pixels
- `V_ACTIVE`, 480, visible height in lines
- `SIZE`, 32, square edge length in pixels
- `COORD_W`, 10, width of coordinates, hpos and vpos
- `SPEED_W`, 3, width of per-square speed (pixels/frame)
- `clk`  in  1  system/pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank
- `pause`  in  1  1 = ignore frame_tick (positions frozen)
- `wrap_mode`  in  1  0 = bounce off edges, 1 = wrap around
- `hpos`, `vpos`  in  COORD_W  current beam position
- `display_on`  in  1  beam in visible area
- `cfg_we`  in  1  configuration write strobe
- `cfg_idx`  in  4  target square index
- `cfg_sel`  in  2  0 = speed, 1 = x, 2 = y, 3 = toggle dx/dy (cfg_data[0] = dx, [1] = dy)
- `cfg_data`  in  COORD_W  write data; speed uses low SPEED_W bits
- `rgb`  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- `hit`  out  1  any square covers the pixel, registered
- `busy`  out  1  update sequencer active
- `frame_done`  out  1  one-cycle pulse after the last square is updated
- `overrun`  out  1  sticky: frame_tick arrived while busy
- `bounce_count`  out  8  wrapping count of direction flips

## Operation
- Reset values, square i: x = i·(H_ACTIVE/N_SQUARES), y = i·(V_ACTIVE/N_SQUARES), dx = + for even i and − for odd i, dy = +, speed = min(i+1, 2^SPEED_W−1). The parameter set must keep the reset y values ≤ V_ACTIVE−SIZE.
- All outputs reset to 0.
- Sequencer FSM states:
  - IDLE → UPDATE when `frame_tick & ~pause`. The index counter k is cleared to 0.
  - UPDATE: square k is updated on both axes in one cycle. k increments. After k = N_SQUARES−1, the FSM returns to IDLE and pulses `frame_done`.
  - `busy` = (state == UPDATE).
- Bounce mode, axis with MAX = H_ACTIVE−SIZE (x) or V_ACTIVE−SIZE (y):
  - Moving +: if x+speed > MAX, then x = MAX and dir flips. Otherwise x += speed.
  - Moving −: if x < speed, then x = 0 and dir flips. Otherwise x −= speed.
  - Each flip adds 1 to `bounce_count`, so a corner adds 2.
  - A configured x > MAX is treated as the + overflow case.
- Wrap mode, with LIM = H_ACTIVE (x) or V_ACTIVE (y):
  - Moving +: x = x+speed, minus LIM if the sum is ≥ LIM.
  - Moving −: x = x−speed, plus LIM if x < speed.
  - Direction never flips and `bounce_count` is unchanged.
- Arithmetic is done COORD_W+1 bits wide, with no truncation before the compare.
- Configuration writes are applied on the cycle `cfg_we` is high. Writes with cfg_idx ≥ N_SQUARES are ignored.
  - If a write and an update target the same square in the same cycle, the write wins for the selected field. The other fields still take the update result.
- Pixel path: square i covers the pixel when x_i ≤ hpos < x_i+SIZE and y_i ≤ vpos < y_i+SIZE.
  - The lowest covering index wins.
  - Colours by i mod 4: 110000, 001100, 000011, 111100. Background is 000000.
  - When `display_on` = 0, rgb = 0 and hit = 0.
- `overrun` is set when `frame_tick` arrives while busy, and is cleared only by `rst`. That tick is otherwise ignored.

## Timing
- `rgb` and `hit` reflect the hpos/vpos/display_on values from the previous cycle (1-cycle latency).
- An update takes N_SQUARES cycles: busy is high on cycles 1..N after the tick, and frame_done is high on cycle N.
- The new position of square k is visible to the pixel path from the cycle after its UPDATE cycle.
- `rst` asserted mid-update aborts the sequence immediately (asynchronously) and restores all reset values.
- A frame_tick while pause = 1 is ignored and does not set overrun.

## Test plan
- Reset, then release → square 1 at (160,120) moving (−,+) with speed 2, rgb = 0, busy = 0; sampling pixel (0,0) with display_on gives rgb = 110000 one cycle later.
- Tick → busy high for 4 cycles, frame_done on the 4th, square 0 at (1,1); a second tick on busy cycle 2 → overrun = 1, positions advance only once.
- Square 0 in bounce mode: 608 ticks → x = 608 with dx still +; tick 609 → x = 608, dx = −, bounce_count incremented; tick 610 → x = 607.
- Square 1 in bounce mode: 80 ticks → x = 0; tick 81 → x = 0 and dx flips to +; tick 82 → x = 2.
- wrap_mode = 1, cfg square 0 x = 639 → one tick gives x = 0, dx unchanged, bounce_count unchanged.
- cfg squares 0 and 2 both to (100,100), query (110,110) → rgb = 110000 (index 0 wins); pause = 1 plus a tick → no busy, no overrun.
